// File: rtl/spmv_pkg.sv
// Shared types and defaults for the CSR SpMV sequencer and its accumulate-control delay line.
// Pure declarations; no logic, no latency.
package spmv_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_ROW_W  = 10;
    localparam int DEF_LAT    = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD0   = 3'd1,
        ST_RDN   = 3'd2,
        ST_CHK   = 3'd3,
        ST_ISSUE = 3'd4,
        ST_EMPTY = 3'd5,
        ST_DRAIN = 3'd6,
        ST_DONE  = 3'd7
    } seq_state_t;

    // Per-element accumulate control; the row index travels beside it because its width is a parameter.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic zero;
    } acc_flags_t;

endpackage

// File: rtl/spmv_delay_line.sv
// Shift register carrying the accumulate tuple to the multiply-add output; latency DEPTH cycles.
// Backpressure: stall freezes every stage; reset clears every stage and wins over stall.
module spmv_delay_line
    import spmv_pkg::*;
#(
    parameter int DEPTH = DEF_LAT,
    parameter int ROW_W = DEF_ROW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  acc_flags_t       issue_flags,
    input  logic [ROW_W-1:0] issue_row,
    output acc_flags_t       acc_flags,
    output logic [ROW_W-1:0] acc_row
);

    acc_flags_t       flags_q [DEPTH];
    logic [ROW_W-1:0] row_q   [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                flags_q[i] <= '0;
                row_q[i]   <= '0;
            end
        end else if (!stall) begin
            flags_q[0] <= issue_flags;
            row_q[0]   <= issue_row;
            for (int i = 1; i < DEPTH; i++) begin
                flags_q[i] <= flags_q[i-1];
                row_q[i]   <= row_q[i-1];
            end
        end
    end

    assign acc_flags = flags_q[DEPTH-1];
    assign acc_row   = row_q[DEPTH-1];

endmodule

// File: rtl/csr_spmv_sequencer.sv
// Walks the CSR row-pointer RAM and issues one nonzero index per cycle; acc controls trail issue by LAT.
// Backpressure: stall holds state, counters, delay line and outputs; RAM addresses stay put.
module csr_spmv_sequencer
    import spmv_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ROW_W  = DEF_ROW_W,
    parameter int LAT    = DEF_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic              stall,
    output logic [ROW_W-1:0]  rowptr_addr,
    input  logic [31:0]       rowptr_data,
    output logic              elem_rd,
    output logic [ADDR_W-1:0] elem_addr,
    output logic              acc_valid,
    output logic              acc_first,
    output logic              acc_last,
    output logic              acc_zero,
    output logic [ROW_W-1:0]  acc_row,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ROW_W-1:0]  r_q, r_d;
    logic [ROW_W-1:0]  nrows_q, nrows_d;
    logic [ROW_W-1:0]  raddr_q, raddr_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              first_q, first_d;
    logic              prev_rd0_q;

    acc_flags_t        issue_flags;
    logic [ROW_W-1:0]  issue_row;
    acc_flags_t        acc_flags;

    logic [ADDR_W-1:0] ptr;
    logic              ptr_bad;

    // Pointers wider than the index space are flagged and used truncated.
    assign ptr     = rowptr_data[ADDR_W-1:0];
    assign ptr_bad = |rowptr_data[31:ADDR_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            end_q      <= '0;
            r_q        <= '0;
            nrows_q    <= '0;
            raddr_q    <= '0;
            eaddr_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            first_q    <= 1'b0;
            prev_rd0_q <= 1'b0;
        end else if (!stall) begin
            state_q    <= state_d;
            k_q        <= k_d;
            end_q      <= end_d;
            r_q        <= r_d;
            nrows_q    <= nrows_d;
            raddr_q    <= raddr_d;
            eaddr_q    <= eaddr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            first_q    <= first_d;
            prev_rd0_q <= (state_q == ST_RD0);
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        end_d       = end_q;
        r_d         = r_q;
        nrows_d     = nrows_q;
        raddr_d     = raddr_q;
        eaddr_d     = eaddr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        first_d     = first_q;
        issue_flags = '0;
        issue_row   = r_q;
        elem_rd     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    nrows_d = num_rows;
                    r_d     = '0;
                    cnt_d   = '0;
                    if (num_rows != '0) begin
                        raddr_d = '0;
                        state_d = ST_RD0;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_RD0: begin
                raddr_d = r_q + ROW_W'(1);
                state_d = ST_RDN;
            end
            ST_RDN: begin
                // Later rows start where the previous row ended, so only the first row reads its start.
                if (prev_rd0_q) begin
                    k_d = ptr;
                    if (ptr_bad) err_d = 1'b1;
                end
                state_d = ST_CHK;
            end
            ST_CHK: begin
                end_d = ptr;
                if (ptr_bad) err_d = 1'b1;
                if (ptr > k_q) begin
                    first_d = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    if (ptr < k_q) err_d = 1'b1;
                    state_d = ST_EMPTY;
                end
            end
            ST_ISSUE: begin
                elem_rd           = 1'b1;
                eaddr_d           = k_q;
                k_d               = k_q + ADDR_W'(1);
                first_d           = 1'b0;
                issue_flags.valid = 1'b1;
                issue_flags.first = first_q;
                issue_flags.last  = (k_q == end_q - ADDR_W'(1));
                if (issue_flags.last) begin
                    if (r_q == nrows_q - ROW_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        r_d     = r_q + ROW_W'(1);
                        raddr_d = r_q + ROW_W'(2);
                        state_d = ST_RDN;
                    end
                end
            end
            ST_EMPTY: begin
                issue_flags.valid = 1'b1;
                issue_flags.zero  = 1'b1;
                // A backwards pointer resyncs the walk to the reported row end.
                k_d = end_q;
                if (r_q == nrows_q - ROW_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    r_d     = r_q + ROW_W'(1);
                    raddr_d = r_q + ROW_W'(2);
                    state_d = ST_RDN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(LAT - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    spmv_delay_line #(
        .DEPTH (LAT),
        .ROW_W (ROW_W)
    ) u_delay (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .issue_flags (issue_flags),
        .issue_row   (issue_row),
        .acc_flags   (acc_flags),
        .acc_row     (acc_row)
    );

    assign rowptr_addr = raddr_q;
    assign elem_addr   = (state_q == ST_ISSUE) ? k_q : eaddr_q;
    assign acc_valid   = acc_flags.valid;
    assign acc_first   = acc_flags.first;
    assign acc_last    = acc_flags.last;
    assign acc_zero    = acc_flags.zero;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;

endmodule

// File: tb/tb_csr_spmv_sequencer.sv
// Scoreboard bench for csr_spmv_sequencer: directed matrices, expected events queued per pass.
module tb_csr_spmv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  num_rows;
    logic        stall;
    logic [9:0]  rowptr_addr;
    logic [31:0] rowptr_data;
    logic        elem_rd;
    logic [13:0] elem_addr;
    logic        acc_valid, acc_first, acc_last, acc_zero;
    logic [9:0]  acc_row;
    logic        busy, done, err;

    csr_spmv_sequencer #(.ADDR_W(14), .ROW_W(10), .LAT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_rows    (num_rows),
        .stall       (stall),
        .rowptr_addr (rowptr_addr),
        .rowptr_data (rowptr_data),
        .elem_rd     (elem_rd),
        .elem_addr   (elem_addr),
        .acc_valid   (acc_valid),
        .acc_first   (acc_first),
        .acc_last    (acc_last),
        .acc_zero    (acc_zero),
        .acc_row     (acc_row),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Row-pointer RAM with one-cycle read latency.
    logic [31:0] rp [0:15];
    always @(posedge clk) rowptr_data <= rp[rowptr_addr[3:0]];

    typedef struct { int cyc; logic [13:0] addr; } elem_exp_t;
    typedef struct { int cyc; logic first; logic last; logic zero; logic [9:0] row; } acc_exp_t;

    elem_exp_t elem_q[$];
    acc_exp_t  acc_q[$];
    int        done_q[$];

    int   checks = 0;
    int   failures = 0;
    int   base = 0;
    logic mon_en = 1'b0;
    logic done_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push_elem(input int c, input int a);
        elem_exp_t e;
        e.cyc = c; e.addr = 14'(a);
        elem_q.push_back(e);
    endtask

    task automatic push_acc(input int c, input logic f, input logic l, input logic z, input int row);
        acc_exp_t a;
        a.cyc = c; a.first = f; a.last = l; a.zero = z; a.row = 10'(row);
        acc_q.push_back(a);
    endtask

    task automatic load_rp(input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
        for (int i = 0; i < 16; i++) rp[i] = 32'd0;
        rp[0] = a0; rp[1] = a1; rp[2] = a2; rp[3] = a3;
    endtask

    // Monitor: pops and compares whenever the DUT presents an unstalled event.
    elem_exp_t me;
    acc_exp_t  ma;
    int        md;
    int        rel;
    always @(negedge clk) begin
        if (mon_en && !stall) begin
            rel = cyc - base;
            if (elem_rd) begin
                checks++;
                if (elem_q.size() == 0) begin
                    failures++;
                    $display("FAIL elem: unexpected issue at cyc=%0d addr=%0d", rel, elem_addr);
                end else begin
                    me = elem_q.pop_front();
                    if (me.cyc != rel || me.addr !== elem_addr) begin
                        failures++;
                        $display("FAIL elem: got cyc=%0d addr=%0d want cyc=%0d addr=%0d",
                                 rel, elem_addr, me.cyc, me.addr);
                    end
                end
            end
            if (acc_valid) begin
                checks++;
                if (acc_q.size() == 0) begin
                    failures++;
                    $display("FAIL acc: unexpected strobe at cyc=%0d row=%0d", rel, acc_row);
                end else begin
                    ma = acc_q.pop_front();
                    if (ma.cyc != rel || ma.first !== acc_first || ma.last !== acc_last ||
                        ma.zero !== acc_zero || ma.row !== acc_row) begin
                        failures++;
                        $display("FAIL acc: got cyc=%0d f/l/z=%b%b%b row=%0d want cyc=%0d f/l/z=%b%b%b row=%0d",
                                 rel, acc_first, acc_last, acc_zero, acc_row,
                                 ma.cyc, ma.first, ma.last, ma.zero, ma.row);
                    end
                end
            end
            if (done) begin
                checks++;
                done_seen = 1'b1;
                if (done_q.size() == 0) begin
                    failures++;
                    $display("FAIL done: unexpected pulse at cyc=%0d", rel);
                end else begin
                    md = done_q.pop_front();
                    if (md != rel) begin
                        failures++;
                        $display("FAIL done: got cyc=%0d want cyc=%0d", rel, md);
                    end
                end
            end
        end
    end

    task automatic run_pass(input string name, input int nr, input int st_lo, input int st_hi,
                            input int exp_busy);
        int busy_cnt;
        busy_cnt = 0;
        @(posedge clk); #1;
        base = cyc; done_seen = 1'b0;
        start = 1'b1; num_rows = 10'(nr);
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 1; t < 100 && !done_seen; t++) begin
            stall = (t >= st_lo && t <= st_hi);
            if (busy) busy_cnt++;
            @(posedge clk); #1;
        end
        stall = 1'b0;
        if (!done_seen) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no done want done", name);
        end
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({name, "_elem_left"}, 64'(elem_q.size()), 64'd0);
        check({name, "_acc_left"}, 64'(acc_q.size()), 64'd0);
        check({name, "_done_left"}, 64'(done_q.size()), 64'd0);
        elem_q.delete(); acc_q.delete(); done_q.delete();
    endtask

    task automatic push_main();
        push_elem(4, 0); push_elem(5, 1);
        push_elem(11, 2); push_elem(12, 3); push_elem(13, 4);
        push_acc(8, 1, 0, 0, 0); push_acc(9, 0, 1, 0, 0);
        push_acc(12, 0, 0, 1, 1);
        push_acc(15, 1, 0, 0, 2); push_acc(16, 0, 0, 0, 2); push_acc(17, 0, 1, 0, 2);
        done_q.push_back(18);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stall = 1'b0; num_rows = '0;
        load_rp(32'd0, 32'd2, 32'd2, 32'd5);
        repeat (3) @(posedge clk);
        #1;
        check("rst_elem_rd", 64'(elem_rd), 64'd0);
        check("rst_acc", 64'({acc_valid, acc_first, acc_last, acc_zero}), 64'd0);
        check("rst_acc_row", 64'(acc_row), 64'd0);
        check("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
        check("rst_addrs", 64'({rowptr_addr, elem_addr}), 64'd0);
        rst = 1'b1;
        mon_en = 1'b1;

        push_main();
        run_pass("main", 3, 0, -1, 18);
        check("main_err", 64'(err), 64'd0);

        // Stall across cycles 5-6: the issue at 5 is held and everything after slides by two.
        push_elem(4, 0); push_elem(7, 1);
        push_elem(13, 2); push_elem(14, 3); push_elem(15, 4);
        push_acc(10, 1, 0, 0, 0); push_acc(11, 0, 1, 0, 0);
        push_acc(14, 0, 0, 1, 1);
        push_acc(17, 1, 0, 0, 2); push_acc(18, 0, 0, 0, 2); push_acc(19, 0, 1, 0, 2);
        done_q.push_back(20);
        run_pass("stall", 3, 5, 6, 20);

        done_q.push_back(5);
        run_pass("zero_rows", 0, 0, -1, 5);

        load_rp(32'd0, 32'd3, 32'd1, 32'd0);
        push_elem(4, 0); push_elem(5, 1); push_elem(6, 2);
        push_acc(8, 1, 0, 0, 0); push_acc(9, 0, 0, 0, 0); push_acc(10, 0, 1, 0, 0);
        push_acc(13, 0, 0, 1, 1);
        done_q.push_back(14);
        run_pass("nonmono", 2, 0, -1, 14);
        check("nonmono_err", 64'(err), 64'd1);

        load_rp(32'd0, 32'd2, 32'd2, 32'd5);
        push_main();
        run_pass("err_clear", 3, 0, -1, 18);
        check("err_cleared", 64'(err), 64'd0);

        load_rp(32'd0, 32'h0001_0002, 32'd0, 32'd0);
        push_elem(4, 0); push_elem(5, 1);
        push_acc(8, 1, 0, 0, 0); push_acc(9, 0, 1, 0, 0);
        done_q.push_back(10);
        run_pass("trunc", 1, 0, -1, 10);
        check("trunc_err", 64'(err), 64'd1);

        // Reset during the first issue cycle: that issue is seen, nothing after it.
        load_rp(32'd0, 32'd2, 32'd2, 32'd5);
        push_elem(4, 0);
        @(posedge clk); #1;
        base = cyc;
        start = 1'b1; num_rows = 10'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_elem_rd", 64'(elem_rd), 64'd0);
        check("abort_acc", 64'({acc_valid, acc_first, acc_last, acc_zero}), 64'd0);
        check("abort_busy_done_err", 64'({busy, done, err}), 64'd0);
        check("abort_addrs", 64'({rowptr_addr, elem_addr}), 64'd0);
        rst = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check("abort_elem_left", 64'(elem_q.size()), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);

        push_main();
        run_pass("after_abort", 3, 0, -1, 18);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
